// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: default payload width,
// bubble (nop) value and occupancy counter width.
package pipe_pkg;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned OCC_W      = 2;
  localparam logic [DATA_W_DEF-1:0] BUBBLE_DEF = '0;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between upstream, the stage and downstream.
// The slave modport is the stage itself; the master modport drives it.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_slot.sv
// One holding slot: valid bit plus payload register. Clear wins over load and
// returns the payload to the bubble value so an empty slot always shows it.
module pipe_slot #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE_VAL;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and 1-cycle latency.
// Define PIPE_STAGE_SKID_EN for the two-slot skid variant (in_ready independent of out_ready).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(BUBBLE_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus
);
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_in_ready;
  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic              w_main_load;
  logic              w_main_clear;
  logic [DATA_W-1:0] w_main_d;

  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = w_main_valid & bus.out_ready;

  pipe_slot #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_main (
    .clk     (clk),
    .i_clear (w_main_clear),
    .i_load  (w_main_load),
    .i_data  (w_main_d),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_skid_load;
  logic              w_skid_clear;

  pipe_slot #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_skid (
    .clk     (clk),
    .i_clear (w_skid_clear),
    .i_load  (w_skid_load),
    .i_data  (bus.in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // Skid drains into main first; input only parks in skid while main is stalled.
  always_comb begin
    w_main_load  = 1'b0;
    w_main_clear = rst | flush;
    w_main_d     = bus.in_data;
    w_skid_load  = 1'b0;
    w_skid_clear = rst | flush;
    if (w_out_xfer) begin
      if (w_skid_valid) begin
        w_main_load  = 1'b1;
        w_main_d     = w_skid_data;
        w_skid_clear = 1'b1;
      end else if (w_in_xfer) begin
        w_main_load  = 1'b1;
      end else begin
        w_main_clear = 1'b1;
      end
    end else if (!w_main_valid) begin
      w_main_load = w_in_xfer;
    end else begin
      w_skid_load = w_in_xfer & ~bus.out_ready;
    end
  end

  assign w_in_ready    = ~w_skid_valid & ~rst;
  assign bus.occupancy = OCC_W'(w_main_valid) + OCC_W'(w_skid_valid);
`else
  // Single slot: refill on the same edge the held entry leaves.
  always_comb begin
    w_main_d     = bus.in_data;
    w_main_load  = w_in_xfer;
    w_main_clear = rst | flush | (w_out_xfer & ~w_in_xfer);
  end

  assign w_in_ready    = ~rst & (~w_main_valid | bus.out_ready);
  assign bus.occupancy = OCC_W'(w_main_valid);
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = w_main_data;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; adapts to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned DW = 64;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  pipe_stage_reg_if #(.DATA_W(DW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL('0)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 64'hDEAD; bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL post_rst_data got %h exp 0", bus.out_data); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL post_rst_occ got %0d exp 0", bus.occupancy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_stream();
    logic [63:0] vals [3];
    vals[0] = 64'h1000; vals[1] = 64'h1004; vals[2] = 64'h1008;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = vals[i];
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", i, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin errors++; $display("FAIL stream_out[%0d] got v=%0b %h exp v=1 %h", i, bus.out_valid, bus.out_data, vals[i]); end
      checks++; if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, bus.occupancy); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0) begin errors++; $display("FAIL stream_drain got v=%0b %h exp v=0 0", bus.out_valid, bus.out_data); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ got %0d exp 0", bus.occupancy); end
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_skid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 64'hA;
    tick();
    checks++; if (bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_one got occ=%0d rdy=%0b exp occ=1 rdy=1", bus.occupancy, bus.in_ready); end
    bus.in_data = 64'hB;
    tick();
    checks++; if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_full got occ=%0d rdy=%0b exp occ=2 rdy=0", bus.occupancy, bus.in_ready); end
    checks++; if (bus.out_data !== 64'hA) begin errors++; $display("FAIL skid_hold got %h exp a", bus.out_data); end
    bus.in_data = 64'hF;
    tick();
    checks++; if (bus.occupancy !== 2'd2 || bus.out_data !== 64'hA) begin errors++; $display("FAIL skid_blocked got occ=%0d %h exp occ=2 a", bus.occupancy, bus.out_data); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_rdy_no_comb got %0b exp 0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hB || bus.occupancy !== 2'd1) begin errors++; $display("FAIL skid_drain_b got v=%0b %h occ=%0d exp v=1 b occ=1", bus.out_valid, bus.out_data, bus.occupancy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_rdy_back got %0b exp 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL skid_empty got v=%0b occ=%0d exp v=0 occ=0", bus.out_valid, bus.occupancy); end
  endtask
`else
  task automatic test_no_skid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 64'h11;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h11) begin errors++; $display("FAIL ns_load got v=%0b %h exp v=1 11", bus.out_valid, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ns_stall_rdy got %0b exp 0", bus.in_ready); end
    tick();
    checks++; if (bus.out_data !== 64'h11 || bus.occupancy !== 2'd1) begin errors++; $display("FAIL ns_hold got %h occ=%0d exp 11 occ=1", bus.out_data, bus.occupancy); end
    bus.in_data = 64'h22; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ns_comb_rdy got %0b exp 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_data !== 64'h22 || bus.occupancy !== 2'd1) begin errors++; $display("FAIL ns_pass got %h occ=%0d exp 22 occ=1", bus.out_data, bus.occupancy); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL ns_empty got v=%0b occ=%0d exp v=0 occ=0", bus.out_valid, bus.occupancy); end
  endtask
`endif

  // Fills the stage to its capacity while stalled; returns expected occupancy.
  task automatic fill(output logic [1:0] occ);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 64'h5;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    bus.in_data = 64'h6;
    tick();
    occ = 2'd2;
`else
    occ = 2'd1;
`endif
    bus.in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [1:0] occ;
    fill(occ);
    checks++; if (bus.occupancy !== occ) begin errors++; $display("FAIL flush_fill got %0d exp %0d", bus.occupancy, occ); end
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 64'hC;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL flush_held got v=%0b %h occ=%0d exp v=0 0 occ=0", bus.out_valid, bus.out_data, bus.occupancy); end
    // Empty stage, out_ready high: in_ready is 1 yet the flush must drop the input.
    bus.out_ready = 1'b1; bus.in_data = 64'hD;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_rdy got %0b exp 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL flush_drop got v=%0b occ=%0d exp v=0 occ=0", bus.out_valid, bus.occupancy); end
    flush = 1'b0; bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0) begin errors++; $display("FAIL flush_never got v=%0b %h exp v=0 0", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_rst_flush();
    logic [1:0] occ;
    fill(occ);
    checks++; if (bus.out_data !== 64'h5) begin errors++; $display("FAIL rf_fill got %h exp 5", bus.out_data); end
    rst = 1'b1; flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 64'h77;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rf_rdy got %0b exp 0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL rf_clear got v=%0b %h occ=%0d exp v=0 0 occ=0", bus.out_valid, bus.out_data, bus.occupancy); end
    rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rf_after got v=%0b rdy=%0b exp v=0 rdy=1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 64'h100;
    tick();
    bus.in_data = 64'h200;
    tick();
    checks++; if (bus.out_data !== 64'h200 || bus.occupancy !== 2'd1) begin errors++; $display("FAIL b2b_second got %h occ=%0d exp 200 occ=1", bus.out_data, bus.occupancy); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b exp 0", bus.out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_stream();
`ifdef PIPE_STAGE_SKID_EN
    test_skid();
`else
    test_no_skid();
`endif
    test_flush();
    test_rst_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
